// File: rtl/inert_seq_pkg.sv
// Shared types and constants for the inertial sensor SPI sequencer.
// Holds the FSM encoding, the fixed configuration writes and the rate register map.
package inert_pkg;

   typedef enum logic [2:0] {
      PWRUP,
      INIT_ISSUE,
      INIT_WAIT,
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      VALID
   } state_t;

   localparam int CMD_RD = 15;

   localparam logic [15:0] INIT_CMD [4] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};

   // Pitch L/H, roll L/H, yaw L/H
   localparam logic [6:0] RD_ADDR [6] = '{7'h22, 7'h23, 7'h24, 7'h25, 7'h26, 7'h27};

   function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
      logic [15:0] c;
      c = {1'b0, addr, 8'h00};
      c[CMD_RD] = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/inert_seq_if.sv
// SPI master handshake plus the assembled rate outputs of the sequencer.
// One transaction is outstanding at a time; done closes it, vld marks a new rate triple.
interface inert_seq_if;
   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [7:0]  rd_data;
   logic [15:0] ptch_rt;
   logic [15:0] roll_rt;
   logic [15:0] yaw_rt;
   logic        vld;

   modport master (
      output wrt, cmd, ptch_rt, roll_rt, yaw_rt, vld,
      input  done, rd_data
   );

   modport slave (
      input  wrt, cmd, ptch_rt, roll_rt, yaw_rt, vld,
      output done, rd_data
   );
endinterface

// File: rtl/inert_seq_int_sync.sv
// Two-flop synchronizer for the sensor INT line with a one-cycle rising-edge pulse.
// rise lags the pin by two to three cycles; no backpressure.
module int_sync (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic sync,
   output logic rise
);

   logic s1, s2, s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync = s2;
   assign rise = s2 & ~s3;

endmodule

// File: rtl/inert_seq.sv
// Sensor sequencer: power-up wait, four config writes, then six byte reads per INT edge.
// Next wrt one cycle after done; vld one cycle after the sixth done; one transaction in flight.
module inert_seq
   import inert_pkg::*;
#(
   parameter int unsigned PWRUP_CYC = 16'd65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        INT,
   inert_seq_if.master bus,
   output logic        init_done,
   output logic        busy
);

   localparam int unsigned CW = (PWRUP_CYC == 0) ? 1 : $clog2(PWRUP_CYC + 1);
   localparam logic [CW-1:0] PW_LAST = CW'((PWRUP_CYC == 0) ? 0 : PWRUP_CYC - 1);

   state_t      state;
   logic [CW-1:0] cnt;
   logic [1:0]  i;
   logic [2:0]  j;
   logic        pend;
   logic [7:0]  shadow [6];
   logic [15:0] cmd_q;
   logic [15:0] ptch_q, roll_q, yaw_q;
   logic        vld_q;
   logic        int_rise;
   logic        int_lvl_unused;

   int_sync u_int_sync (
      .clk  (clk),
      .rst  (rst),
      .in   (INT),
      .sync (int_lvl_unused),
      .rise (int_rise)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PWRUP;
         cnt       <= '0;
         i         <= '0;
         j         <= '0;
         pend      <= 1'b0;
         init_done <= 1'b0;
         cmd_q     <= '0;
         ptch_q    <= '0;
         roll_q    <= '0;
         yaw_q     <= '0;
         vld_q     <= 1'b0;
         for (int k = 0; k < 6; k++) shadow[k] <= '0;
      end else begin
         vld_q <= 1'b0;

         // A new edge wins over the clear so an INT during the launch still earns a burst
         if (int_rise && init_done)
            pend <= 1'b1;
         else if (state == IDLE && pend)
            pend <= 1'b0;

         case (state)
            PWRUP: begin
               if (cnt == PW_LAST) begin
                  cmd_q <= INIT_CMD[0];
                  state <= INIT_ISSUE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            INIT_ISSUE: state <= INIT_WAIT;
            INIT_WAIT: begin
               if (bus.done) begin
                  if (i == 2'd3) begin
                     init_done <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     i     <= i + 2'd1;
                     cmd_q <= INIT_CMD[i + 2'd1];
                     state <= INIT_ISSUE;
                  end
               end
            end
            IDLE: begin
               if (pend) begin
                  j     <= '0;
                  cmd_q <= rd_cmd(RD_ADDR[0]);
                  state <= RD_ISSUE;
               end
            end
            RD_ISSUE: state <= RD_WAIT;
            RD_WAIT: begin
               if (bus.done) begin
                  shadow[j] <= bus.rd_data;
                  if (j == 3'd5) begin
                     // Last byte bypasses the shadow so the triple lands with vld
                     ptch_q <= {shadow[1], shadow[0]};
                     roll_q <= {shadow[3], shadow[2]};
                     yaw_q  <= {bus.rd_data, shadow[4]};
                     vld_q  <= 1'b1;
                     state  <= VALID;
                  end else begin
                     j     <= j + 3'd1;
                     cmd_q <= rd_cmd(RD_ADDR[j + 3'd1]);
                     state <= RD_ISSUE;
                  end
               end
            end
            VALID:   state <= IDLE;
            default: state <= PWRUP;
         endcase
      end
   end

   assign bus.wrt     = (state == INIT_ISSUE) || (state == RD_ISSUE);
   assign bus.cmd     = cmd_q;
   assign bus.ptch_rt = ptch_q;
   assign bus.roll_rt = roll_q;
   assign bus.yaw_rt  = yaw_q;
   assign bus.vld     = vld_q;
   assign busy        = (state == INIT_WAIT) || (state == RD_WAIT);

endmodule

// File: tb/tb_inert_seq.sv
// Bench for inert_seq: SPI responder model, command/rate scoreboards and a table of read bursts.
module tb_inert_seq;

   typedef struct packed {
      logic [47:0] bytes;
      logic [15:0] p;
      logic [15:0] r;
      logic [15:0] y;
      logic        rnd;
   } vec_t;

   logic clk;
   logic rst;
   logic int_in;
   logic init_done;
   logic busy;

   inert_seq_if bus();

   inert_seq #(.PWRUP_CYC(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .INT       (int_in),
      .bus       (bus.master),
      .init_done (init_done),
      .busy      (busy)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int wrt_cnt = 0;
   int vld_cnt = 0;
   int fix_dly = 0;
   bit rand_dly = 0;
   bit inj_done = 0;

   logic [15:0] exp_cmd [$];
   logic [7:0]  resp [$];
   logic [47:0] exp_rates [$];
   logic [15:0] init_cmds [4] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};
   vec_t        tbl [6];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d, want < 60000", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wrt"}, bus.wrt, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_vld"}, bus.vld, 0);
      chk({tag, "_init_done"}, init_done, 0);
      chk({tag, "_cmd"}, bus.cmd, 0);
      chk({tag, "_ptch"}, bus.ptch_rt, 0);
      chk({tag, "_roll"}, bus.roll_rt, 0);
      chk({tag, "_yaw"}, bus.yaw_rt, 0);
   endtask

   task automatic push_burst(input vec_t v);
      logic [47:0] b;
      b = v.bytes;
      for (int k = 0; k < 6; k++) begin
         exp_cmd.push_back(16'hA200 + (16'(k) << 8));
         resp.push_back(b[8*k +: 8]);
      end
      exp_rates.push_back({v.p, v.r, v.y});
   endtask

   task automatic pulse_int();
      int_in = 1'b1;
      tick(3);
      int_in = 1'b0;
   endtask

   task automatic wait_vld(input int target, input string name);
      int k;
      k = 0;
      while (vld_cnt < target && k < 3000) begin
         tick(1);
         k++;
      end
      if (vld_cnt < target) fail(name, vld_cnt, target);
   endtask

   // Releases reset on the current negedge and follows the configuration phase
   task automatic release_and_init(input bit early);
      int base, rel, k;
      base = wrt_cnt;
      for (int n = 0; n < 4; n++) exp_cmd.push_back(init_cmds[n]);
      rst = 1'b0;
      rel = cyc;
      if (early) begin
         int_in = 1'b1; tick(1);
         int_in = 1'b0; tick(1);
         int_in = 1'b1; tick(1);
         int_in = 1'b0;
      end
      k = 0;
      while (!bus.wrt && k < 60) begin
         tick(1);
         k++;
      end
      chk("first_wrt_cycle", cyc - rel + 1, 9);
      if (early) begin
         int_in = 1'b1; tick(2);
         int_in = 1'b0;
      end
      k = 0;
      while (!init_done && k < 400) begin
         tick(1);
         k++;
      end
      chk("init_done", init_done, 1);
      tick(20);
      chk("init_wrt_count", wrt_cnt - base, 4);
      chk("idle_busy", busy, 0);
   endtask

   // SPI responder: accepts wrt, answers after a delay, and checks the follow-up cycle
   initial begin
      bit          pending, stale, follow;
      int          dly;
      logic [15:0] c, prev_c;
      pending = 0; stale = 0; follow = 0; dly = 0; c = '0; prev_c = '0;
      bus.done = 1'b0;
      bus.rd_data = 8'h00;
      forever begin
         @(negedge clk);
         bus.done = 1'b0;
         if (follow) begin
            follow = 0;
            if (prev_c == 16'h1460)
               chk("init_done_after_4th", init_done, 1);
            else if (prev_c == 16'hA700)
               chk("vld_after_6th_done", bus.vld, 1);
            else
               chk("wrt_1cyc_after_done", bus.wrt, 1);
         end
         if (rst && pending) stale = 1;
         if (inj_done) begin
            inj_done = 0;
            bus.done = 1'b1;
            bus.rd_data = 8'hEE;
         end else if (pending) begin
            if (dly > 0) begin
               dly--;
            end else begin
               bus.done = 1'b1;
               pending = 0;
               if (!stale) begin
                  bus.rd_data = (c[15] && resp.size() > 0) ? resp.pop_front() : 8'h00;
                  follow = 1;
                  prev_c = c;
                  if (c == 16'h1460) chk("init_done_before_4th", init_done, 0);
               end else begin
                  bus.rd_data = 8'h5A;
               end
               stale = 0;
            end
         end else if (bus.wrt && !rst) begin
            pending = 1;
            stale = 0;
            c = bus.cmd;
            dly = rand_dly ? int'($urandom_range(0, 50)) : fix_dly;
            wrt_cnt++;
            if (exp_cmd.size() == 0) fail("unexpected_wrt", bus.cmd, 0);
            else chk("cmd", bus.cmd, exp_cmd.pop_front());
         end
      end
   end

   // Output monitor: rate scoreboard, vld width, cmd stability and wrt/busy exclusion
   initial begin
      logic        prev_vld;
      logic [15:0] held;
      logic [47:0] e;
      prev_vld = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (busy) chk("cmd_stable", bus.cmd, held);
         if (bus.wrt) begin
            chk("wrt_while_busy", busy, 0);
            held = bus.cmd;
         end
         if (bus.vld) begin
            if (prev_vld) fail("vld_width", 2, 1);
            vld_cnt++;
            if (exp_rates.size() == 0) begin
               fail("unexpected_vld", {bus.ptch_rt, bus.roll_rt, bus.yaw_rt}, 0);
            end else begin
               e = exp_rates.pop_front();
               chk("ptch_rt", bus.ptch_rt, e[47:32]);
               chk("roll_rt", bus.roll_rt, e[31:16]);
               chk("yaw_rt", bus.yaw_rt, e[15:0]);
            end
         end
         prev_vld = bus.vld;
      end
   end

   initial begin
      int base, w0, k, vc;
      tbl[0] = '{48'h9ABC56781234, 16'h1234, 16'h5678, 16'h9ABC, 1'b0};
      tbl[1] = '{48'h000000000000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      tbl[2] = '{48'hFFFFFFFFFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1};
      tbl[3] = '{48'h80007FFF8001, 16'h8001, 16'h7FFF, 16'h8000, 1'b1};
      tbl[4] = '{48'h665544332211, 16'h2211, 16'h4433, 16'h6655, 1'b1};
      tbl[5] = '{48'hF00F3CC35AA5, 16'h5AA5, 16'h3CC3, 16'hF00F, 1'b0};

      rst = 1'b1;
      int_in = 1'b0;
      tick(3);
      chk_zero("reset");

      // INT edges during power-up and configuration must not start a burst
      release_and_init(1);

      // Stray done while idle
      w0 = wrt_cnt;
      vc = vld_cnt;
      inj_done = 1;
      tick(6);
      chk("spurious_done_vld", vld_cnt - vc, 0);
      chk("spurious_done_wrt", wrt_cnt - w0, 0);
      chk("spurious_done_busy", busy, 0);

      for (int t = 0; t < 6; t++) begin
         rand_dly = tbl[t].rnd;
         base = vld_cnt;
         push_burst(tbl[t]);
         pulse_int();
         wait_vld(base + 1, "vld_timeout");
         tick(5);
         chk("hold_ptch", bus.ptch_rt, tbl[t].p);
         chk("hold_roll", bus.roll_rt, tbl[t].r);
         chk("hold_yaw", bus.yaw_rt, tbl[t].y);
         chk("one_vld_per_int", vld_cnt - base, 1);
      end
      rand_dly = 0;

      // INT during the third read queues exactly one follow-on burst
      base = vld_cnt;
      w0 = wrt_cnt;
      push_burst(tbl[0]);
      push_burst(tbl[4]);
      pulse_int();
      k = 0;
      while (wrt_cnt < w0 + 3 && k < 200) begin
         tick(1);
         k++;
      end
      chk("third_read_issued", wrt_cnt - w0, 3);
      int_in = 1'b1;
      tick(2);
      int_in = 1'b0;
      wait_vld(base + 2, "second_burst_timeout");
      tick(30);
      chk("two_bursts_vld", vld_cnt - base, 2);
      chk("two_bursts_wrt", wrt_cnt - w0, 12);

      // Reset while a read is outstanding; its done arrives during power-up
      fix_dly = 10;
      vc = vld_cnt;
      exp_cmd.push_back(16'hA200);
      int_in = 1'b1;
      k = 0;
      while (!busy && k < 50) begin
         tick(1);
         k++;
      end
      int_in = 1'b0;
      chk("rd_wait_busy", busy, 1);
      tick(2);
      rst = 1'b1;
      fix_dly = 0;
      tick(1);
      chk_zero("mid_rst");
      tick(2);
      release_and_init(0);
      chk("mid_rst_no_vld", vld_cnt - vc, 0);

      chk("exp_cmd_left", exp_cmd.size(), 0);
      chk("exp_rates_left", exp_rates.size(), 0);
      chk("resp_left", resp.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
